// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port instruction/data memory of the multi-cycle CPU
// between the CPU (default owner) and a DMA/debug burst master.
//   - CPU_OWN : memory port follows the CPU nets, zero added latency.
//   - DMA_OWN : one burst beat per cycle, CPU stalled if it requests.
// DMA waits at most MAX_WAIT cycles on a busy CPU before a forced grant,
// and a burst never exceeds BURST_MAX beats, so both sides are bounded.
// Optional build macro ARB_PERF_CNT_EN adds o_stall_cnt / o_forced_cnt.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // CPU side
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_cpu_rd,
  input  logic              i_cpu_wr,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  // DMA / debug burst master
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [3:0]        i_dma_len,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_gnt,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_dma_done,
  // memory port
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  input  logic [DATA_W-1:0] i_mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       o_stall_cnt,
  output logic [7:0]        o_forced_cnt
`endif
);

  // Ownership encoding; one bit is enough for the two owners.
  localparam logic [0:0] ST_CPU_OWN = 1'b0;
  localparam logic [0:0] ST_DMA_OWN = 1'b1;

  localparam logic [3:0] C_MAX_WAIT  = 4'(MAX_WAIT);
  localparam logic [3:0] C_BURST_MAX = 4'(BURST_MAX);

  // Registered state
  logic [0:0]        r_state;
  logic [3:0]        r_wait_cnt;
  logic [3:0]        r_beat;
  logic [3:0]        r_len_q;
  logic [ADDR_W-1:0] r_base_q;
  logic              r_we_q;
  logic              r_dma_rvalid;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              r_dma_done;

  // Combinational helpers
  logic              w_cpu_busy;
  logic              w_dma_own;
  logic              w_wait_expired;
  logic              w_grant;
  logic              w_forced;
  logic              w_last_beat;
  logic [3:0]        w_len_clamped;
  logic [ADDR_W-1:0] w_beat_addr;

  assign w_cpu_busy     = i_cpu_rd | i_cpu_wr;
  assign w_dma_own      = (r_state == ST_DMA_OWN);
  assign w_wait_expired = (r_wait_cnt == C_MAX_WAIT);

  // A grant can only be issued from CPU_OWN, so the first cycle after a
  // burst always belongs to the CPU before another grant can take effect.
  assign w_grant  = ~w_dma_own & i_dma_req & (~w_cpu_busy | w_wait_expired);
  // Grant that had to take the port away from a busy CPU.
  assign w_forced = w_grant & w_cpu_busy & w_wait_expired;

  assign w_last_beat = w_dma_own & (r_beat == (r_len_q - 4'd1));

  // Beat address wraps naturally modulo 2^ADDR_W.
  assign w_beat_addr = r_base_q + (ADDR_W'(r_beat) << 2);

  // Clamp the requested burst length into 1..BURST_MAX.
  always_comb begin
    w_len_clamped = i_dma_len;
    if (i_dma_len == 4'd0) begin
      w_len_clamped = 4'd1;
    end else if (i_dma_len > C_BURST_MAX) begin
      w_len_clamped = C_BURST_MAX;
    end
  end

  // Ownership state: grant moves to DMA_OWN, last beat hands back to the CPU.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_CPU_OWN;
    end else if (w_grant) begin
      r_state <= ST_DMA_OWN;
    end else if (w_last_beat) begin
      r_state <= ST_CPU_OWN;
    end
  end

  // DMA wait counter: counts contended cycles, saturates, cleared on grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (w_grant) begin
      r_wait_cnt <= 4'd0;
    end else if (~w_dma_own & i_dma_req & w_cpu_busy & ~w_wait_expired) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Burst descriptor capture at grant, beat counter while the DMA owns the port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base_q <= '0;
      r_we_q   <= 1'b0;
      r_len_q  <= 4'd0;
      r_beat   <= 4'd0;
    end else if (w_grant) begin
      r_base_q <= i_dma_addr;
      r_we_q   <= i_dma_we;
      r_len_q  <= w_len_clamped;
      r_beat   <= 4'd0;
    end else if (w_dma_own) begin
      r_beat   <= w_last_beat ? 4'd0 : (r_beat + 4'd1);
    end
  end

  // Read beat return: data registered, visible the cycle after the beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= '0;
    end else begin
      r_dma_rvalid <= w_dma_own & ~r_we_q;
      if (w_dma_own & ~r_we_q) begin
        r_dma_rdata <= i_mem_rdata;
      end
    end
  end

  // Completion pulse in the cycle after the last beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dma_done <= 1'b0;
    end else begin
      r_dma_done <= w_last_beat;
    end
  end

  // Memory port mux, selected only by the registered owner.
  always_comb begin
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = i_cpu_wdata;
    o_mem_rd    = i_cpu_rd;
    o_mem_wr    = i_cpu_wr;
    if (w_dma_own) begin
      o_mem_addr  = w_beat_addr;
      o_mem_wdata = i_dma_wdata;
      o_mem_rd    = ~r_we_q;
      o_mem_wr    = r_we_q;
    end
  end

  assign o_cpu_rdata  = i_mem_rdata;
  assign o_cpu_stall  = w_dma_own & w_cpu_busy;
  assign o_dma_gnt    = w_dma_own;
  assign o_dma_rvalid = r_dma_rvalid;
  assign o_dma_rdata  = r_dma_rdata;
  assign o_dma_done   = r_dma_done;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [7:0]  r_forced_cnt;

  // Stall cycle counter, saturating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (o_cpu_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Forced grant counter, saturating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_forced_cnt <= 8'd0;
    end else if (w_forced && (r_forced_cnt != 8'hFF)) begin
      r_forced_cnt <= r_forced_cnt + 8'd1;
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_forced_cnt = r_forced_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a random
// phase, all checked every cycle against a transaction-level model that
// keeps the pending burst as a queue of beat addresses.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXW = 4;
  localparam int BMAX = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_rd, cpu_wr;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [3:0]    dma_len;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt, dma_rvalid, dma_done;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]   stall_cnt;
  logic [7:0]    forced_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW), .BURST_MAX(BMAX)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr),
    .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr),
    .i_dma_len(dma_len), .i_dma_wdata(dma_wdata),
    .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid),
    .o_dma_rdata(dma_rdata), .o_dma_done(dma_done),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .i_mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .o_stall_cnt(stall_cnt), .o_forced_cnt(forced_cnt)
`endif
  );

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h1234ABCD;
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  always_comb mem_rdata = mem_word(mem_addr);

  int n_cmp = 0;
  int n_bad = 0;
  int n_grant = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_dma;
  logic [31:0] m_q[$];
  bit          m_we;
  int          m_wait;
  bit          m_rv;
  logic [31:0] m_rdata;
  bit          m_done;
  int          m_stall;
  int          m_forced;

  task automatic model_reset();
    m_dma = 0; m_q.delete(); m_we = 0; m_wait = 0;
    m_rv = 0; m_rdata = '0; m_done = 0; m_stall = 0; m_forced = 0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance model at the rising edge.
  task automatic cycle();
    bit          busy;
    logic [31:0] ea, ewd;
    bit          erd, ewr, est, eg;
    int          len;
    @(negedge clk);
    busy = cpu_rd | cpu_wr;
    if (m_dma) begin
      ea = m_q[0]; erd = !m_we; ewr = m_we; ewd = dma_wdata; est = busy; eg = 1;
    end else begin
      ea = cpu_addr; erd = cpu_rd; ewr = cpu_wr; ewd = cpu_wdata; est = 0; eg = 0;
    end
    chk("mem_addr",   mem_addr,   ea);
    chk("mem_rd",     mem_rd,     erd);
    chk("mem_wr",     mem_wr,     ewr);
    if (ewr) chk("mem_wdata", mem_wdata, ewd);
    chk("cpu_stall",  cpu_stall,  est);
    chk("dma_gnt",    dma_gnt,    eg);
    chk("dma_rvalid", dma_rvalid, m_rv);
    chk("dma_rdata",  dma_rdata,  m_rdata);
    chk("dma_done",   dma_done,   m_done);
    chk("cpu_rdata",  cpu_rdata,  mem_word(ea));
`ifdef ARB_PERF_CNT_EN
    chk("stall_cnt",  stall_cnt,  m_stall);
    chk("forced_cnt", forced_cnt, m_forced);
`endif
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rv = m_dma && !m_we;
      if (m_rv) m_rdata = mem_word(m_q[0]);
      m_done = 0;
      if (m_dma) begin
        if (busy && m_stall < 65535) m_stall++;
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_dma = 0;
          m_done = 1;
        end
      end else if (dma_req) begin
        if (!busy || m_wait == MAXW) begin
          if (busy && m_forced < 255) m_forced++;
          len = (dma_len == 0) ? 1 : ((dma_len > BMAX) ? BMAX : int'(dma_len));
          for (int i = 0; i < len; i++) m_q.push_back(dma_addr + 32'(4 * i));
          m_we = dma_we; m_dma = 1; m_wait = 0;
          n_grant++;
          $display("grant %0d: we=%0d base=%h beats=%0d forced=%0d",
                   n_grant, dma_we, dma_addr, len, busy);
        end else if (busy && m_wait < MAXW) begin
          m_wait++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Uncontended burst: CPU idle, request for one cycle then dropped.
  task automatic idle_burst(input bit we, input logic [31:0] base, input logic [3:0] len);
    cpu_rd = 0; cpu_wr = 0;
    dma_req = 1; dma_we = we; dma_addr = base; dma_len = len;
    cycle();
    dma_req = 0;
    for (int i = 0; i < BMAX + 2; i++) begin
      dma_wdata = $urandom;
      cycle();
    end
  endtask

  // CPU reads every cycle while a read burst waits for a forced grant.
  task automatic forced_read(input logic [3:0] len);
    cpu_rd = 1; cpu_wr = 0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h300; dma_len = len;
    for (int i = 0; i < MAXW + 1; i++) begin
      cpu_addr = {$urandom_range(0, 255), 2'b00};
      cycle();
    end
    dma_req = 0;
    for (int i = 0; i < int'(len) + 2; i++) begin
      cpu_addr = {$urandom_range(0, 255), 2'b00};
      cycle();
    end
    cpu_rd = 0;
  endtask

  initial begin
    cpu_addr = '0; cpu_wdata = '0; cpu_rd = 0; cpu_wr = 0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    rst_n = 1'b0;
    #1;
    // Reset state, with the CPU requesting so a stall would be visible.
    cpu_rd = 1;
    do_reset();

    // CPU-only reads at 0x40.
    cpu_addr = 32'h40;
    repeat (4) cycle();
    cpu_rd = 0;

    // DMA write burst of 3 beats with the CPU idle.
    dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_len = 4'd3;
    cycle();
    dma_req = 0;
    for (int i = 0; i < 3; i++) begin
      dma_wdata = 32'hA + 32'(i);
      cycle();
    end
    repeat (2) cycle();

    // Forced grant against a busy CPU.
    forced_read(4'd2);

    // Length clamps and address wrap.
    idle_burst(1'b0, 32'h0000_0200, 4'd0);
    idle_burst(1'b1, 32'h0000_0400, 4'd15);
    idle_burst(1'b0, 32'hFFFF_FFFC, 4'd2);

    // Reset during beat 2 of a 4-beat burst.
    dma_req = 1; dma_we = 0; dma_addr = 32'h500; dma_len = 4'd4;
    cycle();
    dma_req = 0; cpu_rd = 1; cpu_addr = 32'h40;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt",   dma_gnt,   1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    repeat (6) cycle();
    cpu_rd = 0;

    // Random phase.
    for (int n = 0; n < 500; n++) begin
      cpu_rd    = ($urandom_range(0, 99) < 55);
      cpu_wr    = ($urandom_range(0, 99) < 20);
      cpu_addr  = {$urandom_range(0, 1023), 2'b00};
      cpu_wdata = $urandom;
      dma_req   = ($urandom_range(0, 99) < 30);
      dma_we    = $urandom_range(0, 1);
      dma_len   = 4'($urandom_range(0, 15));
      dma_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : {20'h0, 10'($urandom), 2'b00};
      dma_wdata = $urandom;
      cycle();
    end
    cpu_rd = 0; cpu_wr = 0; dma_req = 0;
    repeat (BMAX + 3) cycle();

`ifdef ARB_PERF_CNT_EN
    // Forced-grant scenario twice from a clean reset.
    do_reset();
    forced_read(4'd2);
    forced_read(4'd2);
    chk("stall_cnt_total",  stall_cnt,  32'd4);
    chk("forced_cnt_total", forced_cnt, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
